sram_pingpong_ctrl: RTL
=======================

SRAM_PINGPONG_CTRL -- requirements
Module: sram_pingpong_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-003 SHALL have parameter TILE_LEN, default 16, words per tile per bank (2..2**ADDR_WIDTH).
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 Port list SHALL be as follows; the clock and reset ports come first.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_valid  in  1  producer word valid
- wr_data  in  DATA_WIDTH  producer word
- wr_ready  out  1  producer word accepted this cycle
- rd_req  in  1  consumer requests next word, level
- rd_grant  out  1  read issued to SRAM this cycle
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read word
- rd_last  out  1  with rd_valid, last word of a tile
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_din  out  DATA_WIDTH  SRAM write data
- sram_select  out  1  SRAM bank select
- sram_dout  in  DATA_WIDTH  SRAM read data, registered one cycle after the read
- bank_full  out  2  per-bank tile-full flags

Function
REQ-006 SHALL keep wr_bank, rd_bank, wr_cnt, rd_cnt (ADDR_WIDTH bits each) and full[1:0]; bank_full SHALL equal full.
REQ-007 Write eligibility: wr_elig = wr_valid && !full[wr_bank]. Read eligibility: rd_elig = rd_req && full[rd_bank].
REQ-008 One SRAM access per cycle. If only one of wr_elig/rd_elig is set, that one is granted. If both are set, the one not granted last time is granted: last_grant register, 0=write, 1=read.
REQ-009 wr_ready = write granted, combinational; on write: sram_we=1, sram_select=wr_bank, sram_addr=wr_cnt, sram_din=wr_data.
REQ-010 rd_grant = read granted; on read: sram_we=0, sram_select=rd_bank, sram_addr=rd_cnt.
REQ-011 Idle cycle: sram_we=0; sram_addr, sram_din and sram_select SHALL hold their previous values.
REQ-012 rd_valid SHALL be rd_grant delayed one cycle; rd_data = sram_dout; rd_last = delayed (rd_cnt==TILE_LEN-1 at grant).
REQ-013 On write, when wr_cnt==TILE_LEN-1, the following SHALL happen: wr_cnt->0, full[wr_bank]->1, wr_bank toggles. Otherwise wr_cnt increments.
REQ-014 On read, when rd_cnt==TILE_LEN-1, the following SHALL happen: rd_cnt->0, full[rd_bank]->0, rd_bank toggles. Otherwise rd_cnt increments.
REQ-015 A set and a clear of full in the same cycle target different banks by construction; both SHALL take effect.
REQ-016 With both banks full, wr_ready SHALL be 0. With both banks empty, rd_grant SHALL be 0. Nothing is dropped; requests wait.
REQ-017 A write completing a tile SHALL make that bank readable on the next cycle, with no same-cycle bypass.

Reset
REQ-018 On rst, the following SHALL be reset: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full=2'b00, last_grant=1 (the next contention goes to write), rd_valid=0, rd_last=0, sram_addr=0, sram_din=0, sram_select=0.
REQ-019 Reset mid-tile SHALL discard partial tiles and full flags. The rd_valid of an in-flight read SHALL be suppressed. No SRAM clear is required.

Structure
REQ-020 Package sram_pp_pkg SHALL hold the GRANT_WR/GRANT_RD constants and the bank-index width.
REQ-021 The two-requester round-robin SHALL be sub-module rr_arb2 (req[1:0], grant[1:0], last_grant register); counters and flags stay in the top.

Verification (TILE_LEN=4)
REQ-022 Reset -> bank_full=00, sram_we=0, rd_valid=0. With wr_valid=1 the same cycle, wr_ready=1.
REQ-023 Write 0xA0..0xA3 back-to-back -> sram addr 0..3, select 0. bank_full=01 the cycle after the 4th accept. The 5th word goes to addr 0, select 1.
REQ-024 Fill 8 words, rd_req=0 -> bank_full=11; 9th wr_valid sees wr_ready=0 indefinitely.
REQ-025 Bank 0 full, rd_req held, wr_valid=0 -> rd_grant on 4 consecutive cycles, addr 0..3, select 0. rd_valid follows 1 cycle later with 0xA0..0xA3 and rd_last on 0xA3. bank_full[0] clears after the 4th grant.
REQ-026 Bank 0 full, bank 1 empty, wr_valid and rd_req held -> grants alternate W,R,W,R starting with W. Both tiles complete in 8 cycles.
REQ-027 Assert rst after 2 of 4 writes -> bank_full=00. The next write lands at addr 0, select 0.

Source files
------------

// File: rtl/sram_pp_pkg.sv
// rtl/sram_pp_pkg.sv - shared types and constants for the ping-pong SRAM controller
package sram_pp_pkg;

  // Which side of the single SRAM port was granted on the last contended cycle.
  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // Two banks, so one bit selects a bank.
  localparam int BANK_IDX_W = 1;
  typedef logic [BANK_IDX_W-1:0] bank_idx_t;

  // Bit positions of the two requesters in the arbiter request/grant vectors.
  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter for the single SRAM port
module rr_arb2
  import sram_pp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  grant_e last_grant_d;
  grant_e last_grant_q;

  // Lone requester always wins; on contention the side that lost last contention wins.
  always_comb begin
    grant        = req;
    last_grant_d = last_grant_q;
    if (&req) begin
      grant = '0;
      if (last_grant_q == GRANT_RD) begin
        grant[REQ_WR] = 1'b1;
        last_grant_d  = GRANT_WR;
      end else begin
        grant[REQ_RD] = 1'b1;
        last_grant_d  = GRANT_RD;
      end
    end
  end

  // History only moves on contended cycles; reset makes the first contention go to write.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_RD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_pingpong_ctrl.sv
// rtl/sram_pingpong_ctrl.sv - ping-pong tile buffer controller over a two-bank single-port SRAM
module sram_pingpong_ctrl
  import sram_pp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_LEN   = 16
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  output logic                  rd_grant,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_select,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [1:0]            bank_full
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TILE_LEN - 1);

  bank_idx_t             wr_bank_d, wr_bank_q;
  bank_idx_t             rd_bank_d, rd_bank_q;
  logic [ADDR_WIDTH-1:0] wr_cnt_d, wr_cnt_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_d, rd_cnt_q;
  logic [1:0]            full_d, full_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] din_d, din_q;
  bank_idx_t             sel_d, sel_q;
  logic                  rd_valid_d, rd_valid_q;
  logic                  rd_last_d, rd_last_q;

  logic                  wr_elig;
  logic                  rd_elig;
  logic [1:0]            arb_req;
  logic [1:0]            arb_grant;
  logic                  wr_go;
  logic                  rd_go;
  logic                  wr_tile_done;
  logic                  rd_tile_done;

  // A writer may only fill a bank the reader has drained; a reader only drains a full bank.
  always_comb begin
    wr_elig          = wr_valid && !full_q[wr_bank_q];
    rd_elig          = rd_req && full_q[rd_bank_q];
    arb_req          = '0;
    arb_req[REQ_WR]  = wr_elig;
    arb_req[REQ_RD]  = rd_elig;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .grant (arb_grant)
  );

  assign wr_go        = arb_grant[REQ_WR];
  assign rd_go        = arb_grant[REQ_RD];
  assign wr_tile_done = wr_go && (wr_cnt_q == LAST_IDX);
  assign rd_tile_done = rd_go && (rd_cnt_q == LAST_IDX);

  // Drive the SRAM port for the granted access; idle cycles hold the last address/data/bank.
  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    sel_d  = sel_q;
    if (wr_go) begin
      addr_d = wr_cnt_q;
      din_d  = wr_data;
      sel_d  = wr_bank_q;
    end else if (rd_go) begin
      addr_d = rd_cnt_q;
      sel_d  = rd_bank_q;
    end
  end

  // Advance tile counters, swap banks at tile ends and track which banks hold a complete tile.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (wr_go) begin
      if (wr_tile_done) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    // The read bank is always full and the write bank never is, so these never collide.
    if (rd_go) begin
      if (rd_tile_done) begin
        rd_cnt_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Read data returns one cycle after the grant, so valid and last are delayed to match.
  always_comb begin
    rd_valid_d = rd_go;
    rd_last_d  = rd_tile_done;
  end

  // State registers; reset drops partial tiles and any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      full_q     <= 2'b00;
      addr_q     <= '0;
      din_q      <= '0;
      sel_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      full_q     <= full_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      sel_q      <= sel_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign wr_ready    = wr_go;
  assign rd_grant    = rd_go;
  assign sram_we     = wr_go;
  assign sram_addr   = addr_d;
  assign sram_din    = din_d;
  assign sram_select = sel_d;
  assign rd_valid    = rd_valid_q;
  assign rd_last     = rd_last_q;
  assign rd_data     = sram_dout;
  assign bank_full   = full_q;

endmodule
